// File: rtl/keccak_f_iter_if.sv
// Handshake bundle for the iterative Keccak-p core: state in, state out, status.
// Lanes are indexed [x][y]; lane (0,0) is [0][0].
interface keccak_f_iter_if #(
    parameter int W = 64
);
    logic                      in_valid;
    logic                      in_ready;
    logic [4:0][4:0][W-1:0]    in_state;
    logic                      out_valid;
    logic                      out_ready;
    logic [4:0][4:0][W-1:0]    out_state;
    logic                      busy;
    logic [4:0]                round_idx;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy, round_idx
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy, round_idx
    );
endinterface

// File: rtl/keccak_f_iter.sv
// Iterative Keccak-p[25W, NR] permutation, RPC rounds per clock, with valid/ready
// handshakes on both sides. Lanes are indexed [x][y].
module keccak_f_iter #(
    parameter int W   = 64,
    parameter int NR  = 12 + 2 * $clog2(W),
    parameter int RPC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    keccak_f_iter_if.slave  bus
);
    localparam int L   = $clog2(W);
    localparam int IR0 = 12 + 2 * L - NR;

    typedef logic [4:0][4:0][W-1:0] state_t;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_t;

    if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32 || W == 64)) begin : g_err_w
        $error("keccak_f_iter: W must be a power of two no larger than 64");
    end
    if (NR < 1 || NR > 12 + 2 * L) begin : g_err_nr
        $error("keccak_f_iter: NR out of range 1..12+2L");
    end
    if (RPC < 1 || (NR % RPC) != 0) begin : g_err_rpc
        $error("keccak_f_iter: RPC must divide NR");
    end

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
        logic [W-1:0] r;
        int           s;
        r = '0;
        s = n % W;
        for (int i = 0; i < W; i++) begin
            r[(i + s) % W] = v[i];
        end
        return r;
    endfunction

    function automatic int rho_off(input int x, input int y);
        case (5 * x + y)
            0: return 0;    1: return 36;   2: return 3;    3: return 41;   4: return 18;
            5: return 1;    6: return 44;   7: return 10;   8: return 45;   9: return 2;
            10: return 62;  11: return 6;   12: return 43;  13: return 15;  14: return 61;
            15: return 28;  16: return 55;  17: return 25;  18: return 21;  19: return 56;
            20: return 27;  21: return 20;  22: return 39;  23: return 8;   24: return 14;
            default: return 0;
        endcase
    endfunction

    // Full 64-bit constants; every set bit sits at 2^j-1, so truncation yields the W-bit constant.
    function automatic logic [W-1:0] rc_w(input int ir);
        logic [63:0] full;
        case (ir)
            0:  full = 64'h0000_0000_0000_0001;
            1:  full = 64'h0000_0000_0000_8082;
            2:  full = 64'h8000_0000_0000_808A;
            3:  full = 64'h8000_0000_8000_8000;
            4:  full = 64'h0000_0000_0000_808B;
            5:  full = 64'h0000_0000_8000_0001;
            6:  full = 64'h8000_0000_8000_8081;
            7:  full = 64'h8000_0000_0000_8009;
            8:  full = 64'h0000_0000_0000_008A;
            9:  full = 64'h0000_0000_0000_0088;
            10: full = 64'h0000_0000_8000_8009;
            11: full = 64'h0000_0000_8000_000A;
            12: full = 64'h0000_0000_8000_808B;
            13: full = 64'h8000_0000_0000_008B;
            14: full = 64'h8000_0000_0000_8089;
            15: full = 64'h8000_0000_0000_8003;
            16: full = 64'h8000_0000_0000_8002;
            17: full = 64'h8000_0000_0000_0080;
            18: full = 64'h0000_0000_0000_800A;
            19: full = 64'h8000_0000_8000_000A;
            20: full = 64'h8000_0000_8000_8081;
            21: full = 64'h8000_0000_0000_8080;
            22: full = 64'h0000_0000_8000_0001;
            23: full = 64'h8000_0000_8000_8008;
            default: full = 64'h0000_0000_0000_0000;
        endcase
        return full[W-1:0];
    endfunction

    function automatic state_t keccak_round(input state_t a, input logic [W-1:0] rc);
        logic [4:0][W-1:0] c;
        logic [4:0][W-1:0] d;
        state_t            b;
        state_t            o;
        b = '0;
        for (int x = 0; x < 5; x++) begin
            c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
        end
        for (int x = 0; x < 5; x++) begin
            d[x] = c[(x + 4) % 5] ^ rotl(c[(x + 1) % 5], 1);
        end
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                b[y][(2 * x + 3 * y) % 5] = rotl(a[x][y] ^ d[x], rho_off(x, y));
            end
        end
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                o[x][y] = b[x][y] ^ (~b[(x + 1) % 5][y] & b[(x + 2) % 5][y]);
            end
        end
        o[0][0] = o[0][0] ^ rc;
        return o;
    endfunction

    fsm_t       fsm_r;
    fsm_t       fsm_next_s;
    state_t     state_r;
    state_t     round_s;
    logic [4:0] round_idx_r;
    logic       last_s;
    logic       in_ready_r;
    logic       out_valid_r;
    logic       busy_r;

    // Unrolled chain of RPC rounds starting at the current round index
    always_comb begin
        round_s = state_r;
        for (int k = 0; k < RPC; k++) begin
            round_s = keccak_round(round_s, rc_w(IR0 + int'(round_idx_r) + k));
        end
    end

    // Next-state logic for the job sequencer
    always_comb begin
        fsm_next_s = fsm_r;
        last_s     = (int'(round_idx_r) == NR - RPC);
        case (fsm_r)
            IDLE: begin
                if (bus.in_valid) fsm_next_s = RUN;
                else              fsm_next_s = IDLE;
            end
            RUN: begin
                if (last_s) fsm_next_s = DONE;
                else        fsm_next_s = RUN;
            end
            DONE: begin
                if (bus.out_ready) fsm_next_s = IDLE;
                else               fsm_next_s = DONE;
            end
            default: fsm_next_s = IDLE;
        endcase
    end

    // State register and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            fsm_r       <= fsm_next_s;
            in_ready_r  <= (fsm_next_s == IDLE);
            out_valid_r <= (fsm_next_s == DONE);
            busy_r      <= (fsm_next_s == RUN);
        end
    end

    // Permutation state and round counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= '0;
            round_idx_r <= 5'd0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_r     <= bus.in_state;
                        round_idx_r <= 5'd0;
                    end
                end
                RUN: begin
                    state_r     <= round_s;
                    round_idx_r <= last_s ? 5'd0 : round_idx_r + 5'(RPC);
                end
                default: begin
                    state_r     <= state_r;
                    round_idx_r <= round_idx_r;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.round_idx = round_idx_r;
    assign bus.out_state = state_r;
endmodule

// File: tb/tb_keccak_f_iter.sv
// Randomised bench for keccak_f_iter: six configurations checked against a
// sponge-level Keccak-p reference (LFSR round constants, walked rho offsets).
module tb_keccak_f_iter;
    typedef logic [4:0][4:0][63:0] st64_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    st64_t      tin  [6];
    st64_t      tout [6];
    logic [5:0] tv, tordy, tirdy, tov, tbusy;
    logic [4:0] tidx [6];
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    function automatic int cfg_w(input int g);
        case (g)
            3: return 8;
            4: return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int cfg_nr(input int g);
        case (g)
            3: return 18;
            4: return 12;
            5: return 1;
            default: return 24;
        endcase
    endfunction

    function automatic int cfg_rpc(input int g);
        case (g)
            1: return 2;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    for (genvar g = 0; g < 6; g++) begin : g_dut
        localparam int GW = cfg_w(g);
        keccak_f_iter_if #(.W(GW)) bus ();
        assign bus.in_valid  = tv[g];
        assign bus.out_ready = tordy[g];
        assign tirdy[g]      = bus.in_ready;
        assign tov[g]        = bus.out_valid;
        assign tbusy[g]      = bus.busy;
        assign tidx[g]       = bus.round_idx;
        for (genvar x = 0; x < 5; x++) begin : g_x
            for (genvar y = 0; y < 5; y++) begin : g_y
                assign bus.in_state[x][y] = tin[g][x][y][GW-1:0];
                assign tout[g][x][y]      = 64'(bus.out_state[x][y]);
            end
        end
        keccak_f_iter #(.W(GW), .NR(cfg_nr(g)), .RPC(cfg_rpc(g))) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] rot(input logic [63:0] v, input int n, input int w);
        int s;
        s = n % w;
        if (s == 0) return v & wmask(w);
        return ((v << s) | ((v & wmask(w)) >> (w - s))) & wmask(w);
    endfunction

    // rc(t) from the degree-8 LFSR x^8+x^6+x^5+x^4+1
    function automatic logic rc_bit(input int t);
        logic [7:0] r;
        logic [8:0] r9;
        r = 8'h01;
        for (int i = 1; i <= t % 255; i++) begin
            r9 = {r, 1'b0};
            r9[0] = r9[0] ^ r9[8];
            r9[4] = r9[4] ^ r9[8];
            r9[5] = r9[5] ^ r9[8];
            r9[6] = r9[6] ^ r9[8];
            r = r9[7:0];
        end
        return r[0];
    endfunction

    function automatic int log2i(input int w);
        int l = 0;
        while ((1 << l) < w) l++;
        return l;
    endfunction

    function automatic logic [63:0] round_const(input int ir, input int w);
        logic [63:0] v = 64'd0;
        for (int j = 0; j <= log2i(w); j++) v[(1 << j) - 1] = rc_bit(j + 7 * ir);
        return v;
    endfunction

    function automatic st64_t permute(input st64_t a_in, input int w, input int nr);
        logic [63:0] a [5][5];
        logic [63:0] b [5][5];
        logic [63:0] c [5];
        logic [63:0] d;
        int          rho [5][5];
        int          x, y, tmp;
        st64_t       res;
        rho[0][0] = 0;
        x = 1; y = 0;
        for (int t = 0; t < 24; t++) begin
            rho[x][y] = ((t + 1) * (t + 2) / 2) % w;
            tmp = y; y = (2 * x + 3 * y) % 5; x = tmp;
        end
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) a[i][j] = a_in[i][j] & wmask(w);
        for (int r = 0; r < nr; r++) begin
            for (int i = 0; i < 5; i++) c[i] = a[i][0] ^ a[i][1] ^ a[i][2] ^ a[i][3] ^ a[i][4];
            for (int i = 0; i < 5; i++) begin
                d = c[(i + 4) % 5] ^ rot(c[(i + 1) % 5], 1, w);
                for (int j = 0; j < 5; j++) a[i][j] = a[i][j] ^ d;
            end
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) b[j][(2 * i + 3 * j) % 5] = rot(a[i][j], rho[i][j], w);
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    a[i][j] = (b[i][j] ^ (~b[(i + 1) % 5][j] & b[(i + 2) % 5][j])) & wmask(w);
            a[0][0] = a[0][0] ^ round_const(12 + 2 * log2i(w) - nr + r, w);
        end
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) res[i][j] = a[i][j];
        return res;
    endfunction

    function automatic st64_t rand_state(input int w);
        st64_t s;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) s[i][j] = {$urandom(), $urandom()} & wmask(w);
        return s;
    endfunction

    task automatic run_job(input int i, input st64_t st, input bit hold, input string tag,
                           input logic [63:0] kat, input bit use_kat);
        st64_t exp;
        int    n;
        exp = permute(st, cfg_w(i), cfg_nr(i));
        tin[i] = st;
        tv[i]  = 1'b1;
        @(posedge clk); #1;
        tv[i] = 1'b0;
        check_eq({tag, " busy"}, 64'(tbusy[i]), 64'd1);
        check_eq({tag, " in_ready"}, 64'(tirdy[i]), 64'd0);
        n = 0;
        while (tov[i] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, " latency"}, 64'(n), 64'(cfg_nr(i) / cfg_rpc(i)));
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                check_eq($sformatf("%s lane[%0d][%0d]", tag, x, y), tout[i][x][y], exp[x][y]);
        if (use_kat) check_eq({tag, " known lane00"}, tout[i][0][0], kat);
        if (hold) begin
            for (int c = 0; c < 10; c++) begin
                tv[i]  = (c % 2 == 0);
                tin[i] = ~st;
                @(posedge clk); #1;
                check_eq({tag, " hold lane00"}, tout[i][0][0], exp[0][0]);
                check_eq({tag, " hold lane44"}, tout[i][4][4], exp[4][4]);
                check_eq({tag, " hold in_ready"}, 64'(tirdy[i]), 64'd0);
                check_eq({tag, " hold out_valid"}, 64'(tov[i]), 64'd1);
            end
            tv[i]  = 1'b0;
            tin[i] = st;
        end
        tordy[i] = 1'b1;
        @(posedge clk); #1;
        tordy[i] = 1'b0;
        check_eq({tag, " drained out_valid"}, 64'(tov[i]), 64'd0);
        check_eq({tag, " drained in_ready"}, 64'(tirdy[i]), 64'd1);
        check_eq({tag, " drained busy"}, 64'(tbusy[i]), 64'd0);
    endtask

    initial begin
        st64_t zero;
        int    n;
        zero  = '0;
        tv    = '0;
        tordy = '0;
        for (int g = 0; g < 6; g++) tin[g] = '0;
        #12;
        for (int g = 0; g < 6; g++) begin
            check_eq($sformatf("reset in_ready %0d", g), 64'(tirdy[g]), 64'd1);
            check_eq($sformatf("reset out_valid %0d", g), 64'(tov[g]), 64'd0);
            check_eq($sformatf("reset busy %0d", g), 64'(tbusy[g]), 64'd0);
            check_eq($sformatf("reset round_idx %0d", g), 64'(tidx[g]), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        check_eq("model rc0", round_const(0, 64), 64'h0000_0000_0000_0001);
        check_eq("model rc1", round_const(1, 64), 64'h0000_0000_0000_8082);
        check_eq("model rc23", round_const(23, 64), 64'h8000_0000_8000_8008);

        run_job(0, zero, 1'b0, "kat24", 64'hF125_8F79_40E1_DDE7, 1'b1);
        run_job(5, zero, 1'b0, "rc23", 64'h8000_0000_8000_8008, 1'b1);
        for (int k = 0; k < 3; k++) begin
            st64_t s;
            s = rand_state(64);
            run_job(0, s, 1'b0, "rpc1", 64'd0, 1'b0);
            run_job(1, s, 1'b0, "rpc2", 64'd0, 1'b0);
            run_job(2, s, 1'b0, "rpc3", 64'd0, 1'b0);
            run_job(3, rand_state(8), 1'b0, "w8", 64'd0, 1'b0);
            run_job(4, rand_state(16), 1'b0, "w16", 64'd0, 1'b0);
        end
        run_job(0, rand_state(64), 1'b1, "bp", 64'd0, 1'b0);
        run_job(0, rand_state(64), 1'b0, "bp next", 64'd0, 1'b0);

        // Asynchronous reset in the middle of round 7
        tin[0] = rand_state(64);
        tv[0]  = 1'b1;
        @(posedge clk); #1;
        tv[0] = 1'b0;
        n = 0;
        while (tidx[0] !== 5'd7 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("midrun reached round 7", 64'(tidx[0]), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrun in_ready", 64'(tirdy[0]), 64'd1);
        check_eq("midrun out_valid", 64'(tov[0]), 64'd0);
        check_eq("midrun busy", 64'(tbusy[0]), 64'd0);
        check_eq("midrun round_idx", 64'(tidx[0]), 64'd0);
        check_eq("midrun state lane00", tout[0][0][0], 64'd0);
        check_eq("midrun state lane23", tout[0][2][3], 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_job(0, zero, 1'b0, "post reset kat", 64'hF125_8F79_40E1_DDE7, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
